// File: rtl/fp_wb_pkg.sv
// Shared types for the FPU/integer writeback arbiter: the buffered result entry and an x0 test.
package fp_wb_pkg;

  localparam int REG_W   = 5;
  localparam int XLEN    = 32;
  localparam int ENTRY_W = REG_W + XLEN;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  wd;
  } wb_entry_t;

  function automatic logic is_x0(input logic [REG_W-1:0] rd);
    return (rd == '0);
  endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// In-order FIFO of pending FPU writeback entries; push and pop may occur in the same cycle.
module fp_wb_fifo
  import fp_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_data,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_head,
  output logic               o_full,
  output logic               o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// Register-file writeback arbiter: integer first, then buffered FPU results, plus a RAW/WAW scoreboard.
// Define FP_WB_BYPASS_EN to let an FPU result reach the port in its arrival cycle when the port is idle.
module fp_wb_arbiter
  import fp_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NREG  = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        int_we,
  input  logic [4:0]  int_rd,
  input  logic [31:0] int_wd,
  input  logic        fpu_valid,
  input  logic [4:0]  fpu_rd,
  input  logic [31:0] fpu_wd,
  output logic        fpu_ready,
  input  logic        iss_fpu,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  output logic        stall,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3
);

  logic            w_int_wr;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic            w_pop;
  logic            w_fpu_rdy;
  logic            w_fpu_xfer;
  logic            w_fpu_keep;
  logic            w_bypass;
  logic            w_push;
  wb_entry_t       w_head;
  wb_entry_t       w_fpu_entry;
  wb_entry_t       w_port;
  logic            w_port_we;
  logic            w_port_fpu;
  logic [NREG-1:0] w_pend_eff;
  logic [NREG-1:0] w_pending_nxt;
  logic            w_stall;
  logic [NREG-1:0] r_pending;

  assign w_int_wr    = int_we && !is_x0(int_rd);
  assign w_pop       = reset_n && !w_int_wr && !w_fifo_empty;
  assign w_fpu_rdy   = reset_n && (!w_fifo_full || w_pop);
  assign w_fpu_xfer  = fpu_valid && w_fpu_rdy;
  // An accepted result for x0 completes the handshake but is simply dropped.
  assign w_fpu_keep  = w_fpu_xfer && !is_x0(fpu_rd);
  assign w_fpu_entry = '{rd: fpu_rd, wd: fpu_wd};

`ifdef FP_WB_BYPASS_EN
  assign w_bypass = w_fpu_keep && !w_int_wr && w_fifo_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_fpu_keep && !w_bypass;

  fp_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_data  (w_fpu_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_port_we  = 1'b0;
    w_port_fpu = 1'b0;
    w_port     = '0;
    if (!reset_n) begin
      w_port_we = 1'b0;
    end else if (w_int_wr) begin
      w_port_we = 1'b1;
      w_port    = '{rd: int_rd, wd: int_wd};
    end else if (w_pop) begin
      w_port_we  = 1'b1;
      w_port_fpu = 1'b1;
      w_port     = w_head;
    end else if (w_bypass) begin
      w_port_we  = 1'b1;
      w_port_fpu = 1'b1;
      w_port     = w_fpu_entry;
    end
  end

  // A register whose FPU result is on the port this cycle is already visible to decode
  // through the register file's write-through, so it no longer needs to stall.
  always_comb begin
    w_pend_eff = r_pending;
    if (w_port_fpu) w_pend_eff[w_port.rd] = 1'b0;
    w_pend_eff[0] = 1'b0;
  end

  assign w_stall = reset_n &&
                   (w_pend_eff[dec_rs1] || w_pend_eff[dec_rs2] || w_pend_eff[dec_rd]);

  // Clear is applied first so a same-cycle issue to the same register keeps it pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_port_fpu) w_pending_nxt[w_port.rd] = 1'b0;
    if (iss_fpu && !w_stall && !is_x0(dec_rd)) w_pending_nxt[dec_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign fpu_ready = w_fpu_rdy;
  assign stall     = w_stall;
  assign we3       = w_port_we;
  assign a3        = w_port.rd;
  assign wd3       = w_port.wd;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed and random checks of fp_wb_arbiter with a port-write scoreboard.
`timescale 1ns/1ps
module tb_fp_wb_arbiter;

  localparam int W = 37;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        int_we    = 1'b0;
  logic [4:0]  int_rd    = '0;
  logic [31:0] int_wd    = '0;
  logic        fpu_valid = 1'b0;
  logic [4:0]  fpu_rd    = '0;
  logic [31:0] fpu_wd    = '0;
  logic        iss_fpu   = 1'b0;
  logic [4:0]  dec_rs1   = '0;
  logic [4:0]  dec_rs2   = '0;
  logic [4:0]  dec_rd    = '0;
  logic        fpu_ready;
  logic        stall;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;

  logic [W-1:0] exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_old   = 0;
  logic         m_acc;
  logic [W-1:0] m_e;
  logic         hold;

  fp_wb_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .int_we    (int_we),
    .int_rd    (int_rd),
    .int_wd    (int_wd),
    .fpu_valid (fpu_valid),
    .fpu_rd    (fpu_rd),
    .fpu_wd    (fpu_wd),
    .fpu_ready (fpu_ready),
    .iss_fpu   (iss_fpu),
    .dec_rs1   (dec_rs1),
    .dec_rs2   (dec_rs2),
    .dec_rd    (dec_rd),
    .stall     (stall),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3)
  );

  // Clock and reset: posedge is the active edge, inputs change at negedge.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    int_we    = 1'b0;
    int_rd    = '0;
    int_wd    = '0;
    fpu_valid = 1'b0;
    fpu_rd    = '0;
    fpu_wd    = '0;
    iss_fpu   = 1'b0;
    dec_rs1   = '0;
    dec_rs2   = '0;
    dec_rd    = '0;
  endtask

  task automatic drive_int(input logic [4:0] rd, input logic [31:0] wd);
    int_we = 1'b1;
    int_rd = rd;
    int_wd = wd;
  endtask

  task automatic drive_fpu(input logic [4:0] rd, input logic [31:0] wd);
    fpu_valid = 1'b1;
    fpu_rd    = rd;
    fpu_wd    = wd;
  endtask

  // Scoreboard: every cycle the port must carry the int write, else the oldest queued FPU
  // result, else (bypass build) a result accepted this cycle, else nothing.
  always begin
    @(negedge clk);
    #3;
    if (!reset_n) begin
      check("sb_rst_we3", we3, 0);
      exp_q.delete();
      n_old = 0;
    end else begin
      m_acc = fpu_valid && fpu_ready && (fpu_rd != 5'd0);
      if (int_we && int_rd != 5'd0) begin
        check("sb_int_we3", we3, 1);
        check("sb_int_port", {a3, wd3}, {int_rd, int_wd});
      end else if (n_old > 0) begin
        m_e = exp_q.pop_front();
        n_old--;
        check("sb_fpu_we3", we3, 1);
        check("sb_fpu_port", {a3, wd3}, m_e);
      end
`ifdef FP_WB_BYPASS_EN
      else if (m_acc) begin
        check("sb_byp_we3", we3, 1);
        check("sb_byp_port", {a3, wd3}, {fpu_rd, fpu_wd});
        m_acc = 1'b0;
      end
`endif
      else begin
        check("sb_idle_we3", we3, 0);
      end
      if (m_acc) exp_q.push_back({fpu_rd, fpu_wd});
      n_old = exp_q.size();
    end
  end

  initial begin
    // Reset: outputs forced low even with an int write presented.
    idle();
    drive_int(5'd5, 32'hDEADBEEF);
    dec_rs1 = 5'd9;
    repeat (2) @(negedge clk);
    #1;
    check("rst_we3", we3, 0);
    check("rst_a3", a3, 0);
    check("rst_wd3", wd3, 0);
    check("rst_stall", stall, 0);
    check("rst_fpu_ready", fpu_ready, 0);

    @(negedge clk); reset_n = 1'b1; idle(); #1;
    check("rel_fpu_ready", fpu_ready, 1);
    for (int r = 0; r < 32; r++) begin
      @(negedge clk);
      dec_rs1 = 5'(r);
      dec_rs2 = 5'(31 - r);
      dec_rd  = 5'(r);
      #1;
      check("rel_pend_clear", stall, 0);
    end

    // Integer only, then x0 dropped.
    @(negedge clk); idle(); drive_int(5'd5, 32'h3F800000); #1;
    check("int_we3", we3, 1);
    check("int_a3", a3, 5);
    check("int_wd3", wd3, 32'h3F800000);
    @(negedge clk); int_rd = 5'd0; #1;
    check("int_x0_we3", we3, 0);

    // Conflict: int wins, FPU follows next cycle.
    @(negedge clk); idle(); drive_int(5'd3, 32'h11111111); drive_fpu(5'd7, 32'h40490FDB); #1;
    check("conf_a3_n", a3, 3);
    check("conf_ready", fpu_ready, 1);
    @(negedge clk); idle(); #1;
    check("conf_we3_n1", we3, 1);
    check("conf_a3_n1", a3, 7);
    check("conf_wd3_n1", wd3, 32'h40490FDB);
    @(negedge clk); #1;
    check("conf_idle", we3, 0);

    // Full: int holds the port 4 cycles while FPU offers 8, 9, 10.
    @(negedge clk); idle(); drive_int(5'd11, 32'h0B); drive_fpu(5'd8, 32'h40000008); #1;
    check("full_rdy_c0", fpu_ready, 1);
    @(negedge clk); drive_int(5'd12, 32'h0C); drive_fpu(5'd9, 32'h40000009); #1;
    check("full_rdy_c1", fpu_ready, 1);
    @(negedge clk); drive_int(5'd13, 32'h0D); drive_fpu(5'd10, 32'h4000000A); #1;
    check("full_rdy_c2", fpu_ready, 0);
    @(negedge clk); drive_int(5'd14, 32'h0E); #1;
    check("full_rdy_c3", fpu_ready, 0);
    @(negedge clk); int_we = 1'b0; #1;
    check("full_rdy_c4", fpu_ready, 1);
    check("full_a3_8", a3, 8);
    @(negedge clk); fpu_valid = 1'b0; #1;
    check("full_a3_9", a3, 9);
    @(negedge clk); #1;
    check("full_a3_10", a3, 10);
    check("full_wd3_10", wd3, 32'h4000000A);
    @(negedge clk); #1;
    check("full_idle", we3, 0);

    // Scoreboard on rd=10.
    @(negedge clk); idle(); iss_fpu = 1'b1; dec_rd = 5'd10; #1;
    check("sb_issue_stall", stall, 0);
    @(negedge clk); idle(); dec_rs1 = 5'd10; #1;
    check("sb_rs1_stall", stall, 1);
    @(negedge clk); idle(); dec_rs2 = 5'd10; #1;
    check("sb_rs2_stall", stall, 1);
    @(negedge clk); idle(); dec_rd = 5'd10; #1;
    check("sb_rd_stall", stall, 1);
    @(negedge clk); idle(); dec_rs1 = 5'd10; drive_fpu(5'd10, 32'h41200000); #1;
`ifdef FP_WB_BYPASS_EN
    check("sb_wb_stall", stall, 0);
    check("sb_wb_we3", we3, 1);
    check("sb_wb_a3", a3, 10);
`else
    check("sb_push_stall", stall, 1);
    check("sb_push_we3", we3, 0);
    @(negedge clk); fpu_valid = 1'b0; #1;
    check("sb_wb_stall", stall, 0);
    check("sb_wb_we3", we3, 1);
    check("sb_wb_a3", a3, 10);
`endif
    @(negedge clk); idle(); dec_rs1 = 5'd10; #1;
    check("sb_cleared", stall, 0);
    @(negedge clk); idle(); iss_fpu = 1'b1; dec_rd = 5'd0; #1;
    @(negedge clk); idle(); dec_rs1 = 5'd0; #1;
    check("sb_x0_stall", stall, 0);

    // Idle port: bypass vs. one cycle through the FIFO.
    @(negedge clk); idle(); drive_fpu(5'd4, 32'h40800000); #1;
`ifdef FP_WB_BYPASS_EN
    check("byp_we3", we3, 1);
    check("byp_a3", a3, 4);
    @(negedge clk); idle(); #1;
    check("byp_after", we3, 0);
`else
    check("byp_we3_n", we3, 0);
    @(negedge clk); idle(); #1;
    check("byp_we3_n1", we3, 1);
    check("byp_a3_n1", a3, 4);
`endif

    // Reset mid-operation: two queued results and pending[6].
    @(negedge clk); idle(); iss_fpu = 1'b1; dec_rd = 5'd6;
    drive_int(5'd1, 32'h1); drive_fpu(5'd20, 32'h42000014);
    @(negedge clk); idle(); drive_int(5'd2, 32'h2); drive_fpu(5'd21, 32'h42000015); #1;
    check("mid_ready_c1", fpu_ready, 1);
    @(negedge clk); idle(); drive_int(5'd3, 32'h3); dec_rs1 = 5'd6; #1;
    check("mid_stall6", stall, 1);
    check("mid_full", fpu_ready, 0);
    @(negedge clk); idle(); reset_n = 1'b0; #1;
    check("mid_rst_we3", we3, 0);
    check("mid_rst_ready", fpu_ready, 0);
    @(negedge clk);
    @(negedge clk); reset_n = 1'b1; dec_rs1 = 5'd6; #1;
    check("mid_rel_stall", stall, 0);
    check("mid_rel_we3", we3, 0);
    repeat (3) begin
      @(negedge clk); #1;
      check("mid_quiet_we3", we3, 0);
      check("mid_quiet_stall", stall, 0);
    end

    // Random traffic; the scoreboard checks every port write.
    hold = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      dec_rs1 = '0;
      int_we  = ($urandom_range(0, 2) == 0);
      int_rd  = 5'($urandom_range(0, 31));
      int_wd  = $urandom();
      if (!hold) begin
        fpu_valid = 1'($urandom_range(0, 1));
        fpu_rd    = 5'($urandom_range(0, 31));
        fpu_wd    = $urandom();
      end
      #1;
      check("rnd_stall", stall, 0);
      hold = fpu_valid && !fpu_ready;
    end
    @(negedge clk); idle();
    repeat (6) @(negedge clk);
    #4;
    check("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
